// File: rtl/ebr_ram_param_if.sv
// Request/response bus of the parameterised EBR RAM: write port, read port,
// clear request and the read-data/busy responses.
interface ebr_ram_param_if #(
    parameter int DW = 16,
    parameter int AW = 8
) ();
    logic          WE;
    logic [AW-1:0] WADDR;
    logic [DW-1:0] WDATA;
    logic [DW-1:0] MASK;
    logic          RE;
    logic [AW-1:0] RADDR;
    logic          CLR;
    logic [DW-1:0] RDATA;
    logic          RVALID;
    logic          BUSY;

    modport master (
        output WE, WADDR, WDATA, MASK, RE, RADDR, CLR,
        input  RDATA, RVALID, BUSY
    );

    modport slave (
        input  WE, WADDR, WDATA, MASK, RE, RADDR, CLR,
        output RDATA, RVALID, BUSY
    );
endinterface

// File: rtl/ebr_ram_param.sv
// Parameterised simple dual-port RAM with bit-masked writes, selectable
// read-during-write behaviour, optional output register and zero-fill sweep.
module ebr_ram_param #(
    parameter int DW           = 16,
    parameter int AW           = 8,
    parameter int OUTREG       = 0,
    parameter int RDW_MODE     = 0,
    parameter int CLR_ON_RESET = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    ebr_ram_param_if.slave   bus
);

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    localparam state_e RST_STATE = (CLR_ON_RESET != 0) ? CLEAR : READY;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] old_word;
    logic [DW-1:0] merged;
    logic [DW-1:0] rd_word;

    logic [DW-1:0] mem [2**AW];

    logic [DW-1:0] rdata1_q;
    logic          rvalid1_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // CLR wins over any WE/RE in the same cycle and restarts the sweep at 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        unique case (state_q)
            CLEAR: begin
                busy = 1'b1;
                if (bus.CLR) begin
                    cnt_d = '0;
                end else if (cnt_q == '1) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READY: begin
                if (bus.CLR) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    wr_en = bus.WE;
                    rd_en = bus.RE;
                end
            end
        endcase
    end

    assign bus.BUSY = busy;

    always_comb begin
        old_word = mem[bus.WADDR];
        merged   = (old_word & bus.MASK) | (bus.WDATA & ~bus.MASK);
        rd_word  = mem[bus.RADDR];
        if ((RDW_MODE != 0) && wr_en && (bus.WADDR == bus.RADDR)) begin
            rd_word = merged;
        end
    end

    // Array has no reset; the sweep writes zeros and bypasses MASK.
    always_ff @(posedge CLK) begin
        if (busy) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            mem[bus.WADDR] <= merged;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdata1_q  <= '0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid1_q <= rd_en;
            if (rd_en) begin
                rdata1_q <= rd_word;
            end
        end
    end

    if (OUTREG != 0) begin : g_outreg
        logic [DW-1:0] rdata2_q;
        logic          rvalid2_q;

        // Second stage only advances on a completing read so RDATA holds otherwise.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                rdata2_q  <= '0;
                rvalid2_q <= 1'b0;
            end else begin
                rvalid2_q <= rvalid1_q;
                if (rvalid1_q) begin
                    rdata2_q <= rdata1_q;
                end
            end
        end

        assign bus.RDATA  = rdata2_q;
        assign bus.RVALID = rvalid2_q;
    end else begin : g_direct
        assign bus.RDATA  = rdata1_q;
        assign bus.RVALID = rvalid1_q;
    end

    // Backdoor access for simulation; bypasses the FSM and MASK.
    function automatic logic [DW-1:0] get_word(input logic [AW-1:0] adr);
        return mem[adr];
    endfunction

    function automatic void set_word(input logic [AW-1:0] adr, input logic [DW-1:0] data);
        mem[adr] <= data;
    endfunction

endmodule

// File: tb/tb_ebr_ram_param.sv
// Directed bench: dut1 = OUTREG 0 / RDW old-data, dut2 = OUTREG 1 / RDW new-data,
// both fed from the same request bus.
module tb_ebr_ram_param;

    localparam int DW = 16;
    localparam int AW = 4;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    ebr_ram_param_if #(.DW(DW), .AW(AW)) b1 ();
    ebr_ram_param_if #(.DW(DW), .AW(AW)) b2 ();

    assign b2.WE    = b1.WE;
    assign b2.WADDR = b1.WADDR;
    assign b2.WDATA = b1.WDATA;
    assign b2.MASK  = b1.MASK;
    assign b2.RE    = b1.RE;
    assign b2.RADDR = b1.RADDR;
    assign b2.CLR   = b1.CLR;

    ebr_ram_param #(.DW(DW), .AW(AW), .OUTREG(0), .RDW_MODE(0), .CLR_ON_RESET(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .bus(b1)
    );

    ebr_ram_param #(.DW(DW), .AW(AW), .OUTREG(1), .RDW_MODE(1), .CLR_ON_RESET(1)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .bus(b2)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        b1.WE  = 1'b0;
        b1.RE  = 1'b0;
        b1.CLR = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        idle();
        b1.WADDR = '0; b1.WDATA = '0; b1.MASK = '0; b1.RADDR = '0;
        RST_N = 1'b0;
        tick(); tick();
        checks++; if (b1.RDATA !== 16'h0) begin failures++; $display("FAIL rst_rdata1 got=%h exp=0", b1.RDATA); end
        checks++; if (b1.RVALID !== 1'b0) begin failures++; $display("FAIL rst_rvalid1 got=%b exp=0", b1.RVALID); end
        checks++; if (b2.RDATA !== 16'h0) begin failures++; $display("FAIL rst_rdata2 got=%h exp=0", b2.RDATA); end
        checks++; if (b2.RVALID !== 1'b0) begin failures++; $display("FAIL rst_rvalid2 got=%b exp=0", b2.RVALID); end
        checks++; if (b1.BUSY !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b exp=1", b1.BUSY); end
        RST_N = 1'b1;
        n = 0;
        while (b1.BUSY === 1'b1 && n < 40) begin n++; tick(); end
        checks++; if (n != 16) begin failures++; $display("FAIL rst_sweep_len got=%0d exp=16", n); end
        checks++; if (b2.BUSY !== 1'b0) begin failures++; $display("FAIL rst_busy2_end got=%b exp=0", b2.BUSY); end
    endtask

    task automatic test_clear_reads();
        for (int a = 0; a < 16; a++) begin
            b1.RE = 1'b1; b1.RADDR = AW'(a);
            tick();
            checks++; if (b1.RVALID !== 1'b1 || b1.RDATA !== 16'h0) begin
                failures++; $display("FAIL clr_read1[%0d] got=%b/%h exp=1/0000", a, b1.RVALID, b1.RDATA); end
            if (a > 0) begin
                checks++; if (b2.RVALID !== 1'b1 || b2.RDATA !== 16'h0) begin
                    failures++; $display("FAIL clr_read2[%0d] got=%b/%h exp=1/0000", a - 1, b2.RVALID, b2.RDATA); end
            end
        end
        idle();
        tick();
        checks++; if (b1.RVALID !== 1'b0) begin failures++; $display("FAIL clr_idle1 got=%b exp=0", b1.RVALID); end
        checks++; if (b2.RVALID !== 1'b1) begin failures++; $display("FAIL clr_last2 got=%b exp=1", b2.RVALID); end
        tick();
    endtask

    task automatic test_masked_write();
        b1.WE = 1'b1; b1.WADDR = 4'd3; b1.WDATA = 16'hFFFF; b1.MASK = 16'h00FF;
        tick();
        idle();
        b1.RE = 1'b1; b1.RADDR = 4'd3;
        tick();
        idle();
        checks++; if (b1.RVALID !== 1'b1 || b1.RDATA !== 16'hFF00) begin
            failures++; $display("FAIL mw_lat1 got=%b/%h exp=1/ff00", b1.RVALID, b1.RDATA); end
        checks++; if (b2.RVALID !== 1'b0) begin failures++; $display("FAIL mw_early2 got=%b exp=0", b2.RVALID); end
        tick();
        checks++; if (b1.RVALID !== 1'b0 || b1.RDATA !== 16'hFF00) begin
            failures++; $display("FAIL mw_hold1 got=%b/%h exp=0/ff00", b1.RVALID, b1.RDATA); end
        checks++; if (b2.RVALID !== 1'b1 || b2.RDATA !== 16'hFF00) begin
            failures++; $display("FAIL mw_lat2 got=%b/%h exp=1/ff00", b2.RVALID, b2.RDATA); end
        tick();
        checks++; if (b2.RVALID !== 1'b0 || b2.RDATA !== 16'hFF00) begin
            failures++; $display("FAIL mw_hold2 got=%b/%h exp=0/ff00", b2.RVALID, b2.RDATA); end
    endtask

    task automatic test_rdw();
        dut1.set_word(4'd5, 16'h1234);
        dut2.set_word(4'd5, 16'h1234);
        tick();
        b1.WE = 1'b1; b1.WADDR = 4'd5; b1.WDATA = 16'hABCD; b1.MASK = 16'h0000;
        b1.RE = 1'b1; b1.RADDR = 4'd5;
        tick();
        idle();
        checks++; if (b1.RVALID !== 1'b1 || b1.RDATA !== 16'h1234) begin
            failures++; $display("FAIL rdw_old got=%b/%h exp=1/1234", b1.RVALID, b1.RDATA); end
        checks++; if (dut1.get_word(4'd5) !== 16'hABCD) begin
            failures++; $display("FAIL rdw_mem1 got=%h exp=abcd", dut1.get_word(4'd5)); end
        tick();
        checks++; if (b2.RVALID !== 1'b1 || b2.RDATA !== 16'hABCD) begin
            failures++; $display("FAIL rdw_new got=%b/%h exp=1/abcd", b2.RVALID, b2.RDATA); end
    endtask

    task automatic test_clr_priority();
        int n;
        bit seen_valid;
        dut1.set_word(4'd2, 16'h0F0F);
        dut2.set_word(4'd2, 16'h0F0F);
        b1.RE = 1'b1; b1.RADDR = 4'd3;
        tick();
        checks++; if (b1.RVALID !== 1'b1 || b1.RDATA !== 16'hFF00) begin
            failures++; $display("FAIL cp_pre got=%b/%h exp=1/ff00", b1.RVALID, b1.RDATA); end
        b1.CLR = 1'b1; b1.WE = 1'b1; b1.WADDR = 4'd2; b1.WDATA = 16'h5555; b1.MASK = 16'h0000;
        b1.RE = 1'b1; b1.RADDR = 4'd2;
        tick();
        idle();
        checks++; if (b1.BUSY !== 1'b1) begin failures++; $display("FAIL cp_busy got=%b exp=1", b1.BUSY); end
        checks++; if (b1.RVALID !== 1'b0) begin failures++; $display("FAIL cp_rd_drop got=%b exp=0", b1.RVALID); end
        checks++; if (dut1.get_word(4'd2) !== 16'h0F0F) begin
            failures++; $display("FAIL cp_wr_drop got=%h exp=0f0f", dut1.get_word(4'd2)); end
        checks++; if (b2.RVALID !== 1'b1 || b2.RDATA !== 16'hFF00) begin
            failures++; $display("FAIL cp_inflight got=%b/%h exp=1/ff00", b2.RVALID, b2.RDATA); end
        n = 1;
        seen_valid = 1'b0;
        tick();
        while (b1.BUSY === 1'b1 && n < 40) begin
            if (b1.RVALID !== 1'b0 || b2.RVALID !== 1'b0) seen_valid = 1'b1;
            n++;
            tick();
        end
        checks++; if (n != 16) begin failures++; $display("FAIL cp_sweep_len got=%0d exp=16", n); end
        checks++; if (seen_valid) begin failures++; $display("FAIL cp_valid_busy got=1 exp=0"); end
        b1.RE = 1'b1; b1.RADDR = 4'd2;
        tick();
        idle();
        checks++; if (b1.RVALID !== 1'b1 || b1.RDATA !== 16'h0) begin
            failures++; $display("FAIL cp_after1 got=%b/%h exp=1/0000", b1.RVALID, b1.RDATA); end
        tick();
        checks++; if (b2.RVALID !== 1'b1 || b2.RDATA !== 16'h0) begin
            failures++; $display("FAIL cp_after2 got=%b/%h exp=1/0000", b2.RVALID, b2.RDATA); end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        dut1.set_word(4'd9, 16'h00AA);
        dut2.set_word(4'd9, 16'h00AA);
        tick();
        b1.RE = 1'b1; b1.RADDR = 4'd9;
        tick();
        b1.RE = 1'b0; b1.CLR = 1'b1;
        tick();
        idle();
        checks++; if (b2.RVALID !== 1'b1 || b2.RDATA !== 16'h00AA) begin
            failures++; $display("FAIL ms_pre2 got=%b/%h exp=1/00aa", b2.RVALID, b2.RDATA); end
        repeat (7) tick();
        checks++; if (dut1.cnt_q !== 4'd7) begin failures++; $display("FAIL ms_cnt7 got=%0d exp=7", dut1.cnt_q); end
        RST_N = 1'b0;
        #1;
        checks++; if (b1.RDATA !== 16'h0 || b1.RVALID !== 1'b0) begin
            failures++; $display("FAIL ms_out1 got=%b/%h exp=0/0000", b1.RVALID, b1.RDATA); end
        checks++; if (b2.RDATA !== 16'h0 || b2.RVALID !== 1'b0) begin
            failures++; $display("FAIL ms_out2 got=%b/%h exp=0/0000", b2.RVALID, b2.RDATA); end
        checks++; if (dut1.cnt_q !== 4'd0) begin failures++; $display("FAIL ms_cnt0 got=%0d exp=0", dut1.cnt_q); end
        checks++; if (dut1.get_word(4'd9) !== 16'h00AA) begin
            failures++; $display("FAIL ms_mem_kept got=%h exp=00aa", dut1.get_word(4'd9)); end
        tick(); tick();
        RST_N = 1'b1;
        n = 0;
        while (b1.BUSY === 1'b1 && n < 40) begin n++; tick(); end
        checks++; if (n != 16) begin failures++; $display("FAIL ms_sweep_len got=%0d exp=16", n); end
        checks++; if (dut2.get_word(4'd9) !== 16'h0) begin
            failures++; $display("FAIL ms_mem_swept got=%h exp=0000", dut2.get_word(4'd9)); end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 16; a++) begin
            dut1.set_word(AW'(a), DW'(a));
            dut2.set_word(AW'(a), DW'(a));
        end
        tick();
        for (int a = 0; a < 16; a++) begin
            b1.RE = 1'b1; b1.RADDR = AW'(a);
            tick();
            checks++; if (b1.RVALID !== 1'b1 || b1.RDATA !== DW'(a)) begin
                failures++; $display("FAIL b2b_1[%0d] got=%b/%h exp=1/%h", a, b1.RVALID, b1.RDATA, DW'(a)); end
            if (a > 0) begin
                checks++; if (b2.RVALID !== 1'b1 || b2.RDATA !== DW'(a - 1)) begin
                    failures++; $display("FAIL b2b_2[%0d] got=%b/%h exp=1/%h", a - 1, b2.RVALID, b2.RDATA, DW'(a - 1)); end
            end
        end
        idle();
        tick();
        checks++; if (b2.RVALID !== 1'b1 || b2.RDATA !== 16'h000F) begin
            failures++; $display("FAIL b2b_last2 got=%b/%h exp=1/000f", b2.RVALID, b2.RDATA); end
        checks++; if (b1.RVALID !== 1'b0) begin failures++; $display("FAIL b2b_end1 got=%b exp=0", b1.RVALID); end
        // Independent write and read at different addresses in the same cycle.
        b1.WE = 1'b1; b1.WADDR = 4'd7; b1.WDATA = 16'h1111; b1.MASK = 16'h0000;
        b1.RE = 1'b1; b1.RADDR = 4'd8;
        tick();
        checks++; if (b1.RVALID !== 1'b1 || b1.RDATA !== 16'h0008) begin
            failures++; $display("FAIL ind_rd8 got=%b/%h exp=1/0008", b1.RVALID, b1.RDATA); end
        b1.WADDR = 4'd8; b1.WDATA = 16'h2222; b1.RADDR = 4'd7;
        tick();
        idle();
        checks++; if (b1.RVALID !== 1'b1 || b1.RDATA !== 16'h1111) begin
            failures++; $display("FAIL ind_rd7 got=%b/%h exp=1/1111", b1.RVALID, b1.RDATA); end
        checks++; if (b2.RVALID !== 1'b1 || b2.RDATA !== 16'h0008) begin
            failures++; $display("FAIL ind_rd8_2 got=%b/%h exp=1/0008", b2.RVALID, b2.RDATA); end
        tick();
        checks++; if (b2.RDATA !== 16'h1111 || dut1.get_word(4'd8) !== 16'h2222) begin
            failures++; $display("FAIL ind_wr got=%h/%h exp=1111/2222", b2.RDATA, dut1.get_word(4'd8)); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_clear_reads();
        test_masked_write();
        test_rdw();
        test_clr_priority();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ebr_ram_param.md
EBR_RAM_PARAM -- requirements
Module: ebr_ram_param

Interface
REQ-001 The block SHALL have parameter DW, default 16, data width in bits, legal 1..64.
REQ-002 The block SHALL have parameter AW, default 8, address width in bits, legal 1..12; depth = 2^AW words.
REQ-003 The block SHALL have parameter OUTREG, default 0, which adds one output register stage when set to 1.
REQ-004 The block SHALL have parameter RDW_MODE, default 0, selecting same-address read-during-write behaviour: 0 = old data, 1 = new data.
REQ-005 The block SHALL have parameter CLR_ON_RESET, default 1, which zero-fills memory after reset when set to 1.
REQ-006 Port CLK, input, 1 bit: single clock, all state on rising edge.
REQ-007 Port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-008 Port WE, input, 1 bit: write request.
REQ-009 Port WADDR, input, AW bits: write address.
REQ-010 Port WDATA, input, DW bits: write data.
REQ-011 Port MASK, input, DW bits: per-bit write inhibit; 1 = keep old bit, 0 = write bit.
REQ-012 Port RE, input, 1 bit: read request.
REQ-013 Port RADDR, input, AW bits: read address.
REQ-014 Port CLR, input, 1 bit: synchronous request to zero-fill the memory.
REQ-015 Port RDATA, output, DW bits: read data.
REQ-016 Port RVALID, output, 1 bit: RDATA holds the result of a read this cycle.
REQ-017 Port BUSY, output, 1 bit: clear sweep in progress; WE/RE ignored.

Function
REQ-018 The block SHALL have FSM states CLEAR and READY: BUSY = 1 in CLEAR, 0 in READY.
REQ-019 In CLEAR, each cycle the block SHALL write all-zero to address cnt, ignoring MASK, then increment cnt.
REQ-020 When cnt = 2^AW-1 is written, the FSM SHALL go to READY on the next edge; the sweep takes exactly 2^AW cycles.
REQ-021 CLR = 1 in READY SHALL cause cnt <= 0 and a move to CLEAR on the next edge.
REQ-022 CLR = 1 in CLEAR SHALL restart the sweep with cnt <= 0.
REQ-023 CLR SHALL take priority over a WE/RE presented in the same cycle; that WE/RE is dropped.
REQ-024 In READY, WE = 1 SHALL update mem[WADDR] bit i to WDATA[i] where MASK[i] = 0, leaving bits with MASK[i] = 1 unchanged.
REQ-025 In READY, RE = 1 SHALL return mem[RADDR] on RDATA with latency 1 + OUTREG cycles, with RVALID = 1 in that same cycle only.
REQ-026 When no read completes, RDATA SHALL hold its last value and RVALID SHALL be 0.
REQ-027 For a same-cycle WE and RE with WADDR = RADDR and RDW_MODE = 0, the read SHALL return the pre-write word.
REQ-028 For the same case with RDW_MODE = 1, the read SHALL return the merged word (bit i = MASK[i] ? old : WDATA[i]).
REQ-029 WE and RE at different addresses SHALL be independent, with full throughput of one read and one write per cycle.
REQ-030 Reads in flight when CLR is accepted SHALL still complete with their captured data; no new RVALID SHALL issue while BUSY = 1.
REQ-031 Address values SHALL wrap naturally at AW bits; there is no out-of-range case.
REQ-032 Memory contents SHALL be undefined until the first sweep completes when CLR_ON_RESET = 0.
REQ-033 Under verilator, the block SHALL provide public backdoor functions get_word(adr) and set_word(adr, data) that bypass the FSM and MASK.

Reset
REQ-034 RST_N = 0 SHALL asynchronously force RDATA = 0, RVALID = 0, cnt = 0, all output pipeline registers = 0, and FSM = CLEAR if CLR_ON_RESET = 1, else READY.
REQ-035 Memory array contents SHALL NOT be reset; a reset asserted mid-sweep SHALL restart the sweep from address 0 after release.
REQ-036 BUSY SHALL equal 1 in the first cycle after release when CLR_ON_RESET = 1.

Verification
REQ-037 With AW = 4 and CLR_ON_RESET = 1, after reset release: BUSY SHALL be high for exactly 16 cycles, then every address SHALL read 0 via RE.
REQ-038 Write 0xFFFF with MASK = 0x00FF to address 3 of a cleared array, then read 3: RDATA SHALL be 0xFF00 with RVALID after 1 cycle (OUTREG = 0) or 2 cycles (OUTREG = 1).
REQ-039 mem[5] = 0x1234; same-cycle WE(5, 0xABCD, MASK = 0) and RE(5): RDATA SHALL be 0x1234 when RDW_MODE = 0, and 0xABCD when RDW_MODE = 1.
REQ-040 Assert CLR concurrently with WE(2, 0x5555): the write SHALL be dropped, BUSY SHALL rise next cycle, and mem[2] SHALL read 0 after the sweep.
REQ-041 Assert RST_N = 0 at cnt = 7 mid-sweep: outputs SHALL be 0 immediately, and after release the sweep SHALL restart at 0 and last 2^AW cycles.
REQ-042 Back-to-back reads of addresses 0..15 after backdoor set_word(a, a) SHALL give RVALID high continuously, with RDATA = 0..15 in order.
